timex_fdd_ctrl_latch: RTL and testbench

Clocked replacement for the discrete LS273 control latch and LS244 status buffer behind I/O port 0x3F on the Timex FDD interface. Consumes the active-low port strobes produced by the port decoder. Synchronises them into the interface clock, latches the control byte, and runs the motor spin-up/run-on state machine and the emulated index-pulse generator. Presents a registered status byte back to the Spectrum data bus on port reads.

---
 rtl/timex_fdd_pkg.sv | 39 +++
 rtl/timex_fdd_ctrl_latch_sync_falling_edge.sv | 40 ++++
 rtl/timex_fdd_ctrl_latch.sv | 177 +++++++++++++++++
 tb/tb_timex_fdd_ctrl_latch.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timex_fdd_pkg.sv
// Shared types and bit positions for the Timex FDD port 0x3F control latch
// and status buffer.
package timex_fdd_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SPINUP = 2'd1,
        READY  = 2'd2,
        RUNON  = 2'd3
    } motor_state_t;

    // Control register bit positions
    localparam int CTL_DS0      = 0;
    localparam int CTL_DS1      = 1;
    localparam int CTL_SIDE     = 2;
    localparam int CTL_MOTOR    = 3;
    localparam int CTL_DDEN     = 4;
    localparam int CTL_SPARE_LO = 5;
    localparam int CTL_SPARE_HI = 7;

    // Status byte bit positions
    localparam int STS_INTRQ    = 0;
    localparam int STS_DRQ      = 1;
    localparam int STS_INDEX    = 2;
    localparam int STS_READY    = 3;
    localparam int STS_WPROT    = 4;
    localparam int STS_SPARE_LO = 5;
    localparam int STS_SPARE_HI = 7;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/timex_fdd_ctrl_latch_sync_falling_edge.sv
// Two-flop synchroniser for an active-low strobe, plus a one-clock pulse on
// each synchronised falling edge.
module sync_falling_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // NOTE: every signal assigned in an always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // NOTE: clocked state uses non-blocking assignment so each flop samples the pre-edge value of its source.
    // NOTE: the chain resets low: a strobe already asserted when reset releases never shows a high-to-low
    // transition, so it cannot trigger a capture; a fresh edge needs the line to be seen high first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/timex_fdd_ctrl_latch.sv
// Port 0x3F control latch / status buffer for the Timex FDD interface, with
// motor spin-up/run-on sequencing and an emulated index pulse.
module timex_fdd_ctrl_latch
    import timex_fdd_pkg::*;
#(
    parameter int SPINUP_CYCLES = 8_000_000,
    parameter int RUNON_CYCLES  = 32_000_000,
    parameter int INDEX_PERIOD  = 3_200_000,
    parameter int INDEX_WIDTH   = 64_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       LS273,
    input  logic       nLS244,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic       intrq,
    input  logic       drq,
    input  logic       wprot,
    output logic [1:0] drv_sel,
    output logic       side,
    output logic       motor_on,
    output logic       dden_n,
    output logic [2:0] spare,
    output logic       index_n,
    output logic       ready
);

    localparam int CNT_W = $clog2(max_of4(SPINUP_CYCLES, RUNON_CYCLES, INDEX_PERIOD, INDEX_WIDTH));

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SPIN_LOAD  = CNT_W'(SPINUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUNON_LOAD = CNT_W'(RUNON_CYCLES - 1);
    localparam logic [CNT_W-1:0] REV_LAST   = CNT_W'(INDEX_PERIOD - 1);
    localparam logic [CNT_W-1:0] IDX_LEN    = CNT_W'(INDEX_WIDTH);

    logic wr_level, wr_fall;
    logic rd_level, rd_fall;

    logic [7:0]       din_meta_q, din_meta_d;
    logic [7:0]       din_sync_q, din_sync_d;
    logic [7:0]       ctrl_q, ctrl_d;
    motor_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rev_q, rev_d;
    logic             index_n_q, index_n_d;
    logic [7:0]       status_q, status_d;
    logic             motor_req;

    sync_falling_edge u_wr_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (LS273),
        .level    (wr_level),
        .fall     (wr_fall)
    );

    sync_falling_edge u_rd_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (nLS244),
        .level    (rd_level),
        .fall     (rd_fall)
    );

    // One capture per strobe: the edge pulse lasts a single clock.
    always_comb begin
        din_meta_d = d_in;
        din_sync_d = din_meta_q;
        ctrl_d     = wr_fall ? din_sync_q : ctrl_q;
    end

    assign motor_req = ctrl_q[CTL_MOTOR];

    // Motor sequencer: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Motor sequencer: next state; one counter serves both spin-up and run-on
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            OFF: begin
                if (motor_req) begin
                    state_d = SPINUP;
                    cnt_d   = SPIN_LOAD;
                end
            end
            SPINUP: begin
                if (!motor_req)         state_d = OFF;
                else if (cnt_q == '0)   state_d = READY;
                else                    cnt_d   = cnt_q - CNT_ONE;
            end
            READY: begin
                if (!motor_req) begin
                    state_d = RUNON;
                    cnt_d   = RUNON_LOAD;
                end
            end
            RUNON: begin
                if (motor_req)          state_d = READY;
                else if (cnt_q == '0)   state_d = OFF;
                else                    cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = OFF;
        endcase
    end

    // Motor sequencer: outputs
    always_comb begin
        motor_on = (state_q != OFF);
        ready    = (state_q == READY) || (state_q == RUNON);
    end

    // Revolution counter restarts at 0 on the clock the motor turns on, so the
    // first index pulse coincides with motor_on rising.
    always_comb begin
        rev_d = '0;
        if ((state_q != OFF) && (state_d != OFF)) begin
            rev_d = (rev_q == REV_LAST) ? '0 : rev_q + CNT_ONE;
        end
        index_n_d = (state_d == OFF) || (rev_d >= IDX_LEN);
    end

    always_comb begin
        status_d                            = '0;
        status_d[STS_INTRQ]                 = intrq;
        status_d[STS_DRQ]                   = drq;
        status_d[STS_INDEX]                 = ~index_n_q;
        status_d[STS_READY]                 = ready;
        status_d[STS_WPROT]                 = wprot;
        status_d[STS_SPARE_HI:STS_SPARE_LO] = ctrl_q[CTL_SPARE_HI:CTL_SPARE_LO];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_meta_q <= '0;
            din_sync_q <= '0;
            ctrl_q     <= '0;
            rev_q      <= '0;
            index_n_q  <= 1'b1;
            status_q   <= '0;
        end else begin
            din_meta_q <= din_meta_d;
            din_sync_q <= din_sync_d;
            ctrl_q     <= ctrl_d;
            rev_q      <= rev_d;
            index_n_q  <= index_n_d;
            status_q   <= status_d;
        end
    end

    // Bus enable bypasses the synchroniser so read timing follows the strobe directly.
    assign d_oe    = ~nLS244 & ~rst;
    assign d_out   = status_q;
    assign drv_sel = ctrl_q[CTL_DS1:CTL_DS0];
    assign side    = ctrl_q[CTL_SIDE];
    assign dden_n  = ctrl_q[CTL_DDEN];
    assign spare   = ctrl_q[CTL_SPARE_HI:CTL_SPARE_LO];
    assign index_n = index_n_q;

    a_wr_edge_low: assert property (@(posedge clk) disable iff (rst) wr_fall |-> !wr_level);
    a_rd_edge_low: assert property (@(posedge clk) disable iff (rst) rd_fall |-> !rd_level);
    a_ready_motor: assert property (@(posedge clk) disable iff (rst) ready |-> motor_on);
    a_off_no_idx:  assert property (@(posedge clk) disable iff (rst) (state_q == OFF) |-> index_n_q);
    a_rev_range:   assert property (@(posedge clk) disable iff (rst) rev_q <= REV_LAST);

endmodule

// File: tb/tb_timex_fdd_ctrl_latch.sv
// Self-checking bench for timex_fdd_ctrl_latch: reset, latch vectors, motor
// and index timing, status reads, reset mid-strobe, then randomized traffic.
module tb_timex_fdd_ctrl_latch;

    localparam int S = 20;
    localparam int R = 40;
    localparam int P = 50;
    localparam int W = 5;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       LS273  = 1'b1;
    logic       nLS244 = 1'b1;
    logic [7:0] d_in   = 8'h00;
    logic       intrq  = 1'b0;
    logic       drq    = 1'b0;
    logic       wprot  = 1'b0;

    logic [7:0] d_out;
    logic       d_oe;
    logic [1:0] drv_sel;
    logic       side, motor_on, dden_n, index_n, ready;
    logic [2:0] spare;

    always #5 clk = ~clk;

    timex_fdd_ctrl_latch #(
        .SPINUP_CYCLES (S),
        .RUNON_CYCLES  (R),
        .INDEX_PERIOD  (P),
        .INDEX_WIDTH   (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .LS273    (LS273),
        .nLS244   (nLS244),
        .d_in     (d_in),
        .d_out    (d_out),
        .d_oe     (d_oe),
        .intrq    (intrq),
        .drq      (drq),
        .wprot    (wprot),
        .drv_sel  (drv_sel),
        .side     (side),
        .motor_on (motor_on),
        .dden_n   (dden_n),
        .spare    (spare),
        .index_n  (index_n),
        .ready    (ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic [1:0] ds, input logic sd, input logic dd,
                                         input logic [2:0] sp, input logic mo, input logic rd,
                                         input logic ix_n, input logic [7:0] dout, input logic oe);
        return {13'd0, ds, sd, dd, sp, mo, rd, ix_n, dout, oe};
    endfunction

    function automatic logic [31:0] dut_outs();
        return pack(drv_sel, side, dden_n, spare, motor_on, ready, index_n, d_out, d_oe);
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned at;
        logic [7:0]  data;
    } wr_t;

    int unsigned cyc = 0;
    wr_t         wr_q[$];
    logic [7:0]  m_ctrl   = 8'h00;
    bit          m_on     = 0;
    bit          m_ready  = 0;
    bit          m_runon  = 0;
    int unsigned t_on     = 0;
    int unsigned t_off    = 0;
    logic [7:0]  m_status = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Evaluated mid-cycle: DUT state reflects the last rising edge, and the
    // inputs seen here are what the next rising edge will sample.
    always @(negedge clk) begin
        bit         req, idx;
        logic [7:0] exp_dout;
        if (rst) begin
            m_ctrl = 8'h00; m_on = 0; m_ready = 0; m_runon = 0; m_status = 8'h00;
            wr_q.delete();
            check("model_reset", dut_outs(), pack(2'd0, 0, 0, 3'd0, 0, 0, 1, 8'h00, 0));
        end else begin
            req = m_ctrl[3];
            if (!m_on) begin
                if (req) begin m_on = 1; t_on = cyc; end
            end else if (!m_ready) begin
                if (!req) m_on = 0;
                else if (cyc - t_on == S) m_ready = 1;
            end else if (!m_runon) begin
                if (!req) begin m_runon = 1; t_off = cyc; end
            end else begin
                if (req) m_runon = 0;
                else if (cyc - t_off == R) begin m_on = 0; m_ready = 0; m_runon = 0; end
            end
            while (wr_q.size() > 0 && wr_q[0].at == cyc) m_ctrl = wr_q.pop_front().data;
            idx      = m_on && (((cyc - t_on) % P) < W);
            exp_dout = m_status;
            check("model", dut_outs(),
                  pack(m_ctrl[1:0], m_ctrl[2], m_ctrl[4], m_ctrl[7:5], m_on, m_ready, !idx,
                       exp_dout, !nLS244));
            m_status = {m_ctrl[7:5], wprot, m_ready, idx, drq, intrq};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_begin(input logic [7:0] d);
        LS273 = 1'b0;
        d_in  = d;
        wr_q.push_back('{cyc + 3, d});
    endtask

    task automatic wr_end();
        LS273 = 1'b1;
    endtask

    task automatic rand_cycles(input int n, input bit garble);
        repeat (n) begin
            @(posedge clk);
            #1;
            intrq  = 1'($urandom);
            drq    = 1'($urandom);
            wprot  = 1'($urandom);
            nLS244 = ($urandom_range(0, 3) != 0);
            if (garble) d_in = 8'($urandom);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] ds;
        logic       sd;
        logic       dd;
        logic [2:0] sp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] rd;
        int         hold, gap;
        logic [1:0] prev_ds;
        logic       prev_sd, prev_dd;
        logic [2:0] prev_sp;

        vecs[0] = '{8'h01, 2'b01, 1'b0, 1'b0, 3'b000};
        vecs[1] = '{8'h16, 2'b10, 1'b1, 1'b1, 3'b000};
        vecs[2] = '{8'hE3, 2'b11, 1'b0, 1'b0, 3'b111};
        vecs[3] = '{8'hA4, 2'b00, 1'b1, 1'b0, 3'b101};
        vecs[4] = '{8'h50, 2'b00, 1'b0, 1'b1, 3'b010};
        vecs[5] = '{8'h00, 2'b00, 1'b0, 1'b0, 3'b000};

        // Reset values, with a read strobe held to show d_oe is gated by reset
        nLS244 = 1'b0;
        tick(3);
        check("reset_vals", dut_outs(), pack(2'd0, 0, 0, 3'd0, 0, 0, 1, 8'h00, 0));
        nLS244 = 1'b1;
        rst    = 1'b0;
        tick(3);

        // Latch vectors: old value still visible at +2, new value at +3
        prev_ds = 2'd0; prev_sd = 0; prev_dd = 0; prev_sp = 3'd0;
        foreach (vecs[i]) begin
            wr_begin(vecs[i].data);
            tick(2);
            check("latch_early", {drv_sel, side, dden_n, spare}, {prev_ds, prev_sd, prev_dd, prev_sp});
            tick(1);
            check("latch", {drv_sel, side, dden_n, spare, motor_on},
                  {vecs[i].ds, vecs[i].sd, vecs[i].dd, vecs[i].sp, 1'b0});
            wr_end();
            tick(3);
            prev_ds = vecs[i].ds; prev_sd = vecs[i].sd; prev_dd = vecs[i].dd; prev_sp = vecs[i].sp;
        end

        // Write 0x0D with an 11-clock strobe: spin-up and first index pulse
        wr_begin(8'h0D);
        tick(3);
        check("wr_fields", {drv_sel, side}, {2'b01, 1'b1});
        tick(1);
        check("motor_rise", {motor_on, ready, index_n}, 3'b100);
        tick(4);
        check("index_last_low", index_n, 1'b0);
        tick(1);
        check("index_end", index_n, 1'b1);
        tick(2);
        wr_end();
        tick(12);
        check("ready_not_yet", {motor_on, ready}, 2'b10);
        tick(1);
        check("ready_rise", {motor_on, ready}, 2'b11);

        // Run-on to OFF
        tick(5);
        wr_begin(8'h05);
        tick(3);
        wr_end();
        tick(40);
        check("runon_hold", {motor_on, ready}, 2'b11);
        tick(1);
        check("runon_off", {motor_on, ready, index_n}, 3'b001);

        // Run-on interrupted by a new request: back to READY without spin-up
        tick(3);
        wr_begin(8'h0D);
        tick(3);
        wr_end();
        tick(30);
        check("ready_again", ready, 1'b1);
        wr_begin(8'h05);
        tick(3);
        wr_end();
        tick(17);
        wr_begin(8'h0D);
        tick(3);
        wr_end();
        tick(1);
        check("runon_return", {motor_on, ready}, 2'b11);
        tick(36);
        check("runon_stay", {motor_on, ready}, 2'b11);
        wr_begin(8'h00);
        tick(3);
        wr_end();
        tick(45);
        check("off_after_runon", {motor_on, ready, index_n}, 3'b001);

        // Spin-up abort
        wr_begin(8'h08);
        tick(3);
        wr_end();
        tick(7);
        wr_begin(8'h00);
        tick(3);
        check("abort_spinning", motor_on, 1'b1);
        wr_end();
        tick(1);
        check("abort_off", {motor_on, ready, index_n}, 3'b001);
        tick(30);
        check("abort_no_ready", {motor_on, ready, index_n}, 3'b001);

        // Status read
        wr_begin(8'hA0);
        tick(3);
        wr_end();
        tick(2);
        intrq = 1'b1; wprot = 1'b1; drq = 1'b0;
        tick(2);
        nLS244 = 1'b0;
        #1;
        check("read_oe", d_oe, 1'b1);
        check("read_dout", d_out, 8'hB1);
        intrq = 1'b0;
        #1;
        check("read_lag", d_out, 8'hB1);
        tick(1);
        check("read_update", d_out, 8'hB0);
        nLS244 = 1'b1;
        #1;
        check("read_oe_off", d_oe, 1'b0);
        wprot = 1'b0;
        tick(2);

        // Reset mid-spinup and mid-strobe: immediate reset values, no capture after release
        wr_begin(8'h08);
        tick(3);
        wr_end();
        tick(7);
        wr_begin(8'h3B);
        tick(1);
        rst = 1'b1;
        #1;
        check("async_reset", dut_outs(), pack(2'd0, 0, 0, 3'd0, 0, 0, 1, 8'h00, 0));
        tick(2);
        rst = 1'b0;
        tick(6);
        check("no_capture", {drv_sel, side, dden_n, spare, motor_on}, 8'h00);
        wr_end();
        tick(3);
        wr_begin(8'h03);
        tick(2);
        check("post_reset_early", drv_sel, 2'b00);
        tick(1);
        check("post_reset_wr", drv_sel, 2'b11);
        wr_end();
        tick(3);

        // Randomized traffic, checked every cycle by the model
        for (int w = 0; w < 120; w++) begin
            rd   = 8'($urandom);
            hold = $urandom_range(3, 11);
            gap  = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 90) : $urandom_range(2, 12);
            wr_begin(rd);
            rand_cycles(hold, 1'b0);
            wr_end();
            rand_cycles(gap, 1'b1);
        end
        nLS244 = 1'b1;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
